raw_data_rr_sched: RTL and testbench
====================================

Name: raw_data_rr_sched

Overview:
- Round-robin scheduler that drains NUM_CH raw-data-out FIFOs, each with a paired index FIFO, onto a single raw_data output stream.
- Per grant it pops up to BURST_LEN words from one channel, then moves to the next eligible channel.
- Sits between the per-channel raw data/index FIFOs and the downstream raw data consumer.
- Uses the same valid/accepted handshake the downstream consumer already expects.

Parameters:
NUM_CH, 4, number of requesting FIFO channels (2..16)
DATA_W, 32, raw data word width
IDX_W, 8, index word width
BURST_LEN, 4, max words popped per grant (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ch_enable  in  NUM_CH  per-channel enable mask; 0 = never granted
fifo_empty  in  NUM_CH  per-channel raw data FIFO empty flag
fifo_pop  out  NUM_CH  per-channel pop; pops data and index FIFO together
fifo_rdata  in  NUM_CH*DATA_W  per-channel data, valid one cycle after pop
index_rdata  in  NUM_CH*IDX_W  per-channel index, valid one cycle after pop
raw_data  out  DATA_W  registered output word
raw_index  out  IDX_W  registered output index
raw_ch  out  clog2(NUM_CH)  source channel of the output word
raw_data_valid  out  1  output word valid
raw_data_accepted  in  1  consumer accepts the word; only meaningful while valid
busy  out  1  high whenever state != ARB

Behaviour:
- Reset (synchronous, active-high; applies mid-operation too):
  - state=ARB, last_grant=NUM_CH-1 (channel 0 has first priority), burst_cnt=0.
  - raw_data_valid=0, fifo_pop=0, raw_data/raw_index/raw_ch=0, busy=0.
  - An in-flight word is discarded; the FIFO-side loss is accepted.
- Eligibility: eligible[i] = ch_enable[i] & ~fifo_empty[i].
- ARB:
  - Search eligible channels starting at last_grant+1, wrapping modulo NUM_CH.
  - If a channel c is found: assert fifo_pop[c] combinationally for this cycle only, cur=c, last_grant=c, burst_cnt=0, go to CAPTURE.
  - If none is eligible: stay in ARB with no pops.
- CAPTURE: register fifo_rdata[cur], index_rdata[cur] and cur into raw_data, raw_index, raw_ch; go to READY. No pops.
- READY:
  - raw_data_valid=1. Outputs stay stable until accepted.
  - Accepted, burst_cnt+1 < BURST_LEN, eligible[cur]: pop cur in the same cycle, burst_cnt++, go to CAPTURE.
  - Accepted otherwise (burst done, cur empty, or cur disabled): go to ARB.
  - Not accepted: stay in READY. A ch_enable change does not revoke the current word.
- Latency and throughput:
  - Pop in cycle t; valid from cycle t+2.
  - Best-case sustained rate: 1 word per 2 cycles within a burst; 3 cycles per word across grants.
- At most one fifo_pop bit is high in any cycle. No pop is ever issued to a FIFO whose empty flag is high in that cycle.
- fifo_empty is sampled only in ARB and in the READY accept cycle.
- raw_data_accepted while valid=0 is ignored.
- Illegal or unused state encodings recover to ARB.
- Fairness: a continuously eligible enabled channel is granted within NUM_CH-1 other grants.

Test Plan:
- Reset, then channel 2 only non-empty with words 0xA0..0xA5 and accepted tied high -> pops 4 (BURST_LEN), then 2 more on the next grant; output order 0xA0..0xA5, raw_ch=2, first valid 2 cycles after the first pop.
- All 4 channels non-empty with 1 word each -> grants in order 0,1,2,3; the next round starts at 0; fifo_pop is one-hot on every cycle.
- Valid held with accepted low for 10 cycles -> raw_data, raw_index and raw_ch stable, no pops. Accept on cycle 11 -> next pop occurs in that same cycle.
- Channel 1 goes empty after 2 words of its burst -> after the 2nd accept, state returns to ARB and channel 3 (eligible) is granted next; no pop is issued to channel 1 while empty.
- ch_enable=4'b1010 with all FIFOs non-empty -> only channels 1 and 3 are granted, alternating.
- Reset asserted in CAPTURE -> next cycle valid=0, pops=0; after release, channel 0 has priority.

Source files
------------

// File: rtl/raw_data_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : raw_data_rr_sched
// Purpose  : Round-robin scheduler draining NUM_CH raw-data FIFOs (each with a
//            paired index FIFO) onto one registered raw_data output stream.
//            Each grant pops up to BURST_LEN words from the granted channel.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            ch_enable            - per-channel enable mask (0 = never granted)
//            fifo_empty           - per-channel data FIFO empty flags
//            fifo_pop             - one-hot pop of data + index FIFO
//            fifo_rdata           - per-channel data, valid one cycle after pop
//            index_rdata          - per-channel index, valid one cycle after pop
//            raw_data/raw_index   - registered output word and index
//            raw_ch               - source channel of the output word
//            raw_data_valid       - output word valid
//            raw_data_accepted    - consumer accepts the word while valid
//            busy                 - high whenever the scheduler is not in ARB
// Revision : 1.0 - initial release
// ============================================================================
module raw_data_rr_sched #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic [NUM_CH-1:0]          fifo_empty,
    output logic [NUM_CH-1:0]          fifo_pop,
    input  logic [NUM_CH*DATA_W-1:0]   fifo_rdata,
    input  logic [NUM_CH*IDX_W-1:0]    index_rdata,
    output logic [DATA_W-1:0]          raw_data,
    output logic [IDX_W-1:0]           raw_index,
    output logic [$clog2(NUM_CH)-1:0]  raw_ch,
    output logic                       raw_data_valid,
    input  logic                       raw_data_accepted,
    output logic                       busy
);

    localparam int c_CH_W = $clog2(NUM_CH);

    localparam logic [1:0] c_ST_ARB     = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_READY   = 2'd2;

    localparam logic [c_CH_W:0]   c_NUM_CH    = (c_CH_W+1)'(NUM_CH);
    localparam logic [c_CH_W:0]   c_ONE       = (c_CH_W+1)'(1);
    localparam logic [c_CH_W-1:0] c_LAST_CH   = c_CH_W'(NUM_CH - 1);

    logic [1:0]          r_state;
    logic [c_CH_W-1:0]   r_last_grant;
    logic [c_CH_W-1:0]   r_cur;
    logic [7:0]          r_burst_cnt;
    logic [DATA_W-1:0]   r_raw_data;
    logic [IDX_W-1:0]    r_raw_index;
    logic [c_CH_W-1:0]   r_raw_ch;

    logic [NUM_CH-1:0]   w_eligible;
    logic [2*NUM_CH-1:0] w_elig2;
    logic [c_CH_W:0]     w_shift;
    logic [NUM_CH-1:0]   w_rot;
    logic [c_CH_W-1:0]   w_off;
    logic [c_CH_W:0]     w_sum;
    logic                w_found;
    logic [c_CH_W-1:0]   w_next;
    logic                w_burst_ok;
    logic                w_cont;
    logic [NUM_CH-1:0]   w_pop;

    assign w_eligible = ch_enable & ~fifo_empty;

    // Rotate the doubled eligibility vector so bit 0 is the channel just after
    // last_grant; the lowest set bit is then the round-robin winner.
    assign w_elig2 = {w_eligible, w_eligible};
    assign w_shift = {1'b0, r_last_grant} + c_ONE;
    assign w_rot   = NUM_CH'(w_elig2 >> w_shift);
    assign w_found = |w_rot;

    always_comb begin
        w_off = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_CH_W'(j);
            end
        end
    end

    // Undo the rotation modulo NUM_CH (NUM_CH need not be a power of two).
    assign w_sum  = w_shift + {1'b0, w_off};
    assign w_next = (w_sum >= c_NUM_CH) ? c_CH_W'(w_sum - c_NUM_CH) : w_sum[c_CH_W-1:0];

    assign w_burst_ok = ({1'b0, r_burst_cnt} + 9'd1) < 9'(BURST_LEN);
    assign w_cont     = raw_data_accepted & w_burst_ok & w_eligible[r_cur];

    // Pops are combinational so data arrives in time for CAPTURE; they are
    // suppressed during reset so no word is lost to a pop that cannot complete.
    always_comb begin
        w_pop = '0;
        if (!reset) begin
            case (r_state)
                c_ST_ARB:   if (w_found) w_pop[w_next] = 1'b1;
                c_ST_READY: if (w_cont)  w_pop[r_cur]  = 1'b1;
                default:    w_pop = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_ARB;
            r_last_grant <= c_LAST_CH;
            r_cur        <= '0;
            r_burst_cnt  <= '0;
            r_raw_data   <= '0;
            r_raw_index  <= '0;
            r_raw_ch     <= '0;
        end else begin
            case (r_state)
                c_ST_ARB: begin
                    if (w_found) begin
                        r_cur        <= w_next;
                        r_last_grant <= w_next;
                        r_burst_cnt  <= '0;
                        r_state      <= c_ST_CAPTURE;
                    end
                end
                c_ST_CAPTURE: begin
                    r_raw_data  <= fifo_rdata[int'(r_cur)*DATA_W +: DATA_W];
                    r_raw_index <= index_rdata[int'(r_cur)*IDX_W +: IDX_W];
                    r_raw_ch    <= r_cur;
                    r_state     <= c_ST_READY;
                end
                c_ST_READY: begin
                    if (raw_data_accepted) begin
                        if (w_cont) begin
                            r_burst_cnt <= r_burst_cnt + 8'd1;
                            r_state     <= c_ST_CAPTURE;
                        end else begin
                            r_state     <= c_ST_ARB;
                        end
                    end
                end
                default: r_state <= c_ST_ARB;
            endcase
        end
    end

    assign fifo_pop       = w_pop;
    assign raw_data       = r_raw_data;
    assign raw_index      = r_raw_index;
    assign raw_ch         = r_raw_ch;
    assign raw_data_valid = (r_state == c_ST_READY);
    assign busy           = (r_state != c_ST_ARB);

endmodule
`default_nettype wire

// File: tb/tb_raw_data_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_raw_data_rr_sched
// Purpose  : Self-checking bench for raw_data_rr_sched with per-channel FIFO
//            models and an expected-word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raw_data_rr_sched;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ch_enable;
    logic [3:0]    fifo_empty = 4'hF;
    logic [3:0]    fifo_pop;
    logic [127:0]  fifo_rdata;
    logic [31:0]   index_rdata;
    logic [31:0]   raw_data;
    logic [7:0]    raw_index;
    logic [1:0]    raw_ch;
    logic          raw_data_valid;
    logic          raw_data_accepted;
    logic          busy;

    raw_data_rr_sched #(
        .NUM_CH(4), .DATA_W(32), .IDX_W(8), .BURST_LEN(4)
    ) dut (
        .clk(clk), .reset(reset), .ch_enable(ch_enable), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata), .index_rdata(index_rdata),
        .raw_data(raw_data), .raw_index(raw_index), .raw_ch(raw_ch),
        .raw_data_valid(raw_data_valid), .raw_data_accepted(raw_data_accepted),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  ch;
        logic [7:0]  idx;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int cyc;
        int ch;
    } pop_t;

    exp_t        exp_q[$];
    pop_t        pop_log[$];
    logic [39:0] fq[4][$];
    logic [39:0] rd[4];
    logic [39:0] w_word;
    int          cyc = 0;
    int          pc;
    int          multi_pop_cnt = 0;
    int          bad_pop_cnt = 0;
    logic        load_req = 1'b0;
    logic        flush_req = 1'b0;
    int          load_ch = 0;
    logic [39:0] load_word = '0;
    int          n_cmp = 0;
    int          n_fail = 0;

    for (genvar g = 0; g < 4; g++) begin : g_rd
        assign fifo_rdata[g*32 +: 32] = rd[g][31:0];
        assign index_rdata[g*8 +: 8]  = rd[g][39:32];
    end

    // FIFO models: first-word read one cycle after pop, empty flag registered.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_pop != 4'b0) begin
            pc = 0;
            for (int i = 0; i < 4; i++) if (fifo_pop[i]) pc = i;
            pop_log.push_back('{cyc, pc});
        end
        if (!$onehot0(fifo_pop)) multi_pop_cnt <= multi_pop_cnt + 1;
        if ((fifo_pop & fifo_empty) != 4'b0) bad_pop_cnt <= bad_pop_cnt + 1;
        for (int i = 0; i < 4; i++) begin
            if (fifo_pop[i] && fq[i].size() > 0) begin
                w_word = fq[i].pop_front();
                rd[i] <= w_word;
            end
        end
        if (flush_req) for (int i = 0; i < 4; i++) fq[i].delete();
        if (load_req) fq[load_ch].push_back(load_word);
        for (int i = 0; i < 4; i++) fifo_empty[i] <= (fq[i].size() == 0);
    end

    function automatic logic [7:0] idx_of(input int ch, input logic [31:0] d);
        return {4'(ch), d[3:0]};
    endfunction

    // Number of logged pops since p0 whose channel differs from exp_ch;
    // -1 when the number of pops differs.
    function automatic int seq_diff(input int p0, input int exp_ch[$]);
        int bad;
        if (pop_log.size() - p0 != exp_ch.size()) return -1;
        bad = 0;
        for (int k = 0; k < exp_ch.size(); k++)
            if (pop_log[p0+k].ch != exp_ch[k]) bad++;
        return bad;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [31:0] data);
        load_req  = 1'b1;
        load_ch   = ch;
        load_word = {idx_of(ch, data), data};
        step();
        load_req  = 1'b0;
    endtask

    task automatic expect_word(input int ch, input logic [31:0] data);
        exp_q.push_back('{ch: 2'(ch), idx: idx_of(ch, data), data: data});
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush_req = 1'b1;
        exp_q.delete();
        step();
        flush_req = 1'b0;
        step();
        reset     = 1'b0;
    endtask

    // Scoreboard: pop one expected word per accepted output word.
    task automatic drain(input int n, output int first_cyc);
        exp_t e;
        int   got;
        int   budget;
        got = 0;
        budget = 0;
        first_cyc = -1;
        while (got < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (raw_data_valid && first_cyc < 0) first_cyc = cyc;
            if (raw_data_valid && raw_data_accepted) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_extra: got ch=%0d data=%h, required no word", raw_ch, raw_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({raw_ch, raw_index, raw_data} !== {e.ch, e.idx, e.data}) begin
                        n_fail++;
                        $display("FAIL drain_word: got ch=%0d idx=%h data=%h, required ch=%0d idx=%h data=%h",
                                 raw_ch, raw_index, raw_data, e.ch, e.idx, e.data);
                    end
                end
                got++;
            end
        end
        n_cmp++;
        if (got != n) begin
            n_fail++;
            $display("FAIL drain_count: got %0d words, required %0d", got, n);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ch_enable = 4'b0;
        raw_data_accepted = 1'b0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (raw_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", raw_data_valid); end
        n_cmp++; if (fifo_pop !== 4'b0) begin n_fail++; $display("FAIL reset_pop: got %b, required 0000", fifo_pop); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (raw_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", raw_data); end
        n_cmp++; if (raw_index !== 8'h0) begin n_fail++; $display("FAIL reset_index: got %h, required 0", raw_index); end
        n_cmp++; if (raw_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: got %0d, required 0", raw_ch); end
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if ({busy, fifo_pop} !== 5'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b pop=%b, required 0/0000", busy, fifo_pop); end
        step();
    endtask

    task automatic test_single_channel();
        int p0;
        int fc;
        int v;
        int e6[$];
        e6 = '{2, 2, 2, 2, 2, 2};
        do_reset();
        ch_enable = 4'b0;
        raw_data_accepted = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load(2, 32'hA0 + i);
            expect_word(2, 32'hA0 + i);
        end
        p0 = pop_log.size();
        ch_enable = 4'hF;
        drain(6, fc);
        repeat (3) step();
        v = seq_diff(p0, e6);
        n_cmp++; if (v != 0) begin n_fail++; $display("FAIL single_pops: got diff %0d (pops %0d), required 0 (6 pops on ch2)", v, pop_log.size() - p0); end
        v = (pop_log.size() > p0) ? fc - pop_log[p0].cyc : -99;
        n_cmp++; if (v != 2) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 2", v); end
        v = (pop_log.size() >= p0 + 6) ? pop_log[p0+3].cyc - pop_log[p0+2].cyc : -99;
        n_cmp++; if (v != 2) begin n_fail++; $display("FAIL single_burst_gap: got %0d, required 2", v); end
        v = (pop_log.size() >= p0 + 6) ? pop_log[p0+4].cyc - pop_log[p0+3].cyc : -99;
        n_cmp++; if (v != 3) begin n_fail++; $display("FAIL single_regrant_gap: got %0d, required 3", v); end
    endtask

    task automatic test_round_robin();
        int p0;
        int fc;
        int v;
        int e4[$];
        e4 = '{0, 1, 2, 3};
        do_reset();
        raw_data_accepted = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ch_enable = 4'b0;
            for (int c = 0; c < 4; c++) begin
                load(c, 32'hB0 + 16*r + c);
                expect_word(c, 32'hB0 + 16*r + c);
            end
            p0 = pop_log.size();
            ch_enable = 4'hF;
            drain(4, fc);
            repeat (2) step();
            ch_enable = 4'b0;
            v = seq_diff(p0, e4);
            n_cmp++; if (v != 0) begin n_fail++; $display("FAIL rr_order round %0d: got diff %0d, required 0 (0,1,2,3)", r, v); end
        end
        n_cmp++; if (multi_pop_cnt != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-pop cycles, required 0", multi_pop_cnt); end
    endtask

    task automatic test_hold();
        int waited;
        int pcnt;
        int fc;
        ch_enable = 4'b0;
        raw_data_accepted = 1'b0;
        load(0, 32'hD0);
        load(0, 32'hD1);
        expect_word(0, 32'hD0);
        expect_word(0, 32'hD1);
        ch_enable = 4'b0001;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!raw_data_valid && waited < 20);
        n_cmp++; if (raw_data_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_timeout: got %b, required 1", raw_data_valid); end
        pcnt = pop_log.size();
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            n_cmp++;
            if ({raw_data_valid, raw_ch, raw_index, raw_data} !== {1'b1, exp_q[0].ch, exp_q[0].idx, exp_q[0].data}) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: got v=%b ch=%0d idx=%h data=%h, required v=1 ch=%0d idx=%h data=%h",
                         i, raw_data_valid, raw_ch, raw_index, raw_data, exp_q[0].ch, exp_q[0].idx, exp_q[0].data);
            end
        end
        n_cmp++; if (pop_log.size() != pcnt) begin n_fail++; $display("FAIL hold_no_pop: got %0d pops, required 0", pop_log.size() - pcnt); end
        step();
        raw_data_accepted = 1'b1;
        #1;
        n_cmp++; if (fifo_pop !== 4'b0001) begin n_fail++; $display("FAIL hold_accept_pop: got %b, required 0001", fifo_pop); end
        drain(2, fc);
        ch_enable = 4'b0;
    endtask

    task automatic test_early_empty();
        int p0;
        int fc;
        int v;
        int e4[$];
        e4 = '{1, 1, 3, 3};
        do_reset();
        ch_enable = 4'b0;
        raw_data_accepted = 1'b1;
        load(1, 32'hE0); load(1, 32'hE1); load(3, 32'hF0); load(3, 32'hF1);
        expect_word(1, 32'hE0); expect_word(1, 32'hE1);
        expect_word(3, 32'hF0); expect_word(3, 32'hF1);
        p0 = pop_log.size();
        ch_enable = 4'hF;
        drain(4, fc);
        repeat (2) step();
        v = seq_diff(p0, e4);
        n_cmp++; if (v != 0) begin n_fail++; $display("FAIL empty_order: got diff %0d, required 0 (1,1,3,3)", v); end
        v = (pop_log.size() >= p0 + 4) ? pop_log[p0+2].cyc - pop_log[p0+1].cyc : -99;
        n_cmp++; if (v != 3) begin n_fail++; $display("FAIL empty_regrant_gap: got %0d, required 3", v); end
        n_cmp++; if (bad_pop_cnt != 0) begin n_fail++; $display("FAIL empty_bad_pop: got %0d pops to empty FIFOs, required 0", bad_pop_cnt); end
    endtask

    task automatic test_enable_mask();
        int p0;
        int fc;
        int v;
        int e10[$];
        e10 = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 3};
        do_reset();
        ch_enable = 4'b0;
        raw_data_accepted = 1'b1;
        load(0, 32'h0F);
        load(2, 32'h2F);
        for (int k = 0; k < 5; k++) begin
            load(1, 32'h10 + k);
            load(3, 32'h30 + k);
        end
        for (int k = 0; k < 4; k++) expect_word(1, 32'h10 + k);
        for (int k = 0; k < 4; k++) expect_word(3, 32'h30 + k);
        expect_word(1, 32'h14);
        expect_word(3, 32'h34);
        p0 = pop_log.size();
        ch_enable = 4'b1010;
        drain(10, fc);
        repeat (4) step();
        v = seq_diff(p0, e10);
        n_cmp++; if (v != 0) begin n_fail++; $display("FAIL mask_order: got diff %0d (pops %0d), required 0 (10 pops on 1/3)", v, pop_log.size() - p0); end
        n_cmp++; if (bad_pop_cnt != 0) begin n_fail++; $display("FAIL mask_bad_pop: got %0d, required 0", bad_pop_cnt); end
        ch_enable = 4'b0;
    endtask

    task automatic test_reset_in_capture();
        int p0;
        int fc;
        int v;
        int waited;
        int e3[$];
        e3 = '{0, 1, 2};
        do_reset();
        ch_enable = 4'b0;
        raw_data_accepted = 1'b1;
        load(0, 32'h50); load(1, 32'h61); load(1, 32'h62); load(2, 32'h70);
        expect_word(0, 32'h50);
        expect_word(1, 32'h62);
        expect_word(2, 32'h70);
        ch_enable = 4'b0010;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (fifo_pop == 4'b0 && waited < 20);
        n_cmp++; if (fifo_pop !== 4'b0010) begin n_fail++; $display("FAIL rcap_first_pop: got %b, required 0010", fifo_pop); end
        step();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy, raw_data_valid} !== 2'b10) begin n_fail++; $display("FAIL rcap_in_capture: got busy=%b valid=%b, required 1/0", busy, raw_data_valid); end
        step();
        ch_enable = 4'hF;
        @(negedge clk);
        n_cmp++;
        if ({raw_data_valid, fifo_pop, busy, raw_data} !== {1'b0, 4'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rcap_after_reset: got valid=%b pop=%b busy=%b data=%h, required 0/0000/0/0",
                     raw_data_valid, fifo_pop, busy, raw_data);
        end
        step();
        reset = 1'b0;
        p0 = pop_log.size();
        drain(3, fc);
        repeat (2) step();
        v = seq_diff(p0, e3);
        n_cmp++; if (v != 0) begin n_fail++; $display("FAIL rcap_priority: got diff %0d, required 0 (0,1,2)", v); end
    endtask

    initial begin
        reset = 1'b1;
        ch_enable = 4'b0;
        raw_data_accepted = 1'b0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_hold();
        test_early_empty();
        test_enable_mask();
        test_reset_in_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
